tmds_clk_reset_seq: RTL and testbench
=====================================

Name: tmds_clk_reset_seq

Overview:
- Sits directly downstream of the TMDS PLL.
- Consumes the PLL lock output and generates staged, glitch-free resets for the HDMI output path: first the TMDS serializer (OSER10/CLKDIV), then the pixel/timing/encoder logic.
- Re-asserts both resets whenever lock is lost or software requests a restart.
- Keeps a saturating count of lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the lock synchronizer (min 2).
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before releasing serializer reset.
- STAGGER_CYCLES, 16, cycles between serializer reset release and pixel reset release.
- LOSS_CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  in  1  free-running reference clock (27 MHz board oscillator), independent of the PLL output.
- rst  in  1  synchronous, active-high block reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- soft_restart  in  1  single-cycle request to re-run the sequence.
- rst_serdes  out  1  active-high reset to serializer/CLKDIV.
- rst_pix  out  1  active-high reset to pixel-domain logic.
- ready  out  1  high when both resets are released.
- state  out  2  current FSM state (debug).
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock-loss events.

Behaviour:
- One clock and one synchronous active-high reset. Reset is sampled only on the rising edge of clk.

Reset values, while rst is high:
- rst_serdes=1, rst_pix=1, ready=0.
- state=WAIT_LOCK (0), lock_loss_cnt=0.
- Synchronizer flops and counters cleared to 0.

Lock synchronizer:
- pll_lock passes through a SYNC_STAGES flop chain, giving lock_s.
- Only lock_s is used internally.
- Latency from pll_lock to lock_s is SYNC_STAGES cycles.

FSM encoding: WAIT_LOCK=0, STABILIZE=1, STAGGER=2, RUN=3.

- WAIT_LOCK:
  - rst_serdes=1, rst_pix=1, stable counter held at 0.
  - If lock_s=1, go to STABILIZE.
- STABILIZE:
  - Stable counter increments each cycle with lock_s=1.
  - If lock_s=0, return to WAIT_LOCK and clear the counter. This is not counted as a lock loss.
  - When the counter reaches STABLE_CYCLES-1 with lock_s=1, go to STAGGER.
  - The registered rst_serdes deasserts on the cycle state becomes STAGGER.
  - Total: rst_serdes falls exactly STABLE_CYCLES cycles after the first cycle in STABILIZE.
- STAGGER:
  - rst_serdes=0, rst_pix=1. Stagger counter counts to STAGGER_CYCLES-1, then go to RUN.
  - rst_pix falls and ready rises on entering RUN.
  - If lock_s=0, go to WAIT_LOCK and count a loss.
- RUN:
  - rst_serdes=0, rst_pix=0, ready=1.
  - If lock_s=0, go to WAIT_LOCK and count a loss.
- soft_restart=1 in any state other than WAIT_LOCK:
  - Next state is WAIT_LOCK.
  - Resets assert on the next cycle.
  - No loss is counted.
  - This takes priority over the lock_s-loss transition in the same cycle.
- soft_restart in WAIT_LOCK is ignored.
- Output ordering: resets assert simultaneously, one registered cycle after the triggering condition. rst_pix never deasserts before rst_serdes.
- lock_loss_cnt increments by 1 per loss from STAGGER or RUN. It saturates at all-ones and does not wrap.
- All outputs are registered. No combinational path exists from pll_lock to any output.
- Counters are wide enough for their parameter values: clog2(STABLE_CYCLES) and clog2(STAGGER_CYCLES) bits, each with a minimum of 1.

Test Plan:
- rst held 5 cycles with pll_lock=1 -> all outputs at reset values. After rst falls: rst_serdes falls at cycle SYNC_STAGES+1+1024 (±0, checked exactly), rst_pix and ready change 16 cycles later, state=3.
- pll_lock glitches low for 1 cycle at STABILIZE count 500 -> FSM returns to WAIT_LOCK, lock_loss_cnt stays 0, full 1024-cycle stabilization restarts after lock returns.
- pll_lock drops in RUN -> rst_serdes=1, rst_pix=1 and ready=0 appear SYNC_STAGES+1 cycles later, lock_loss_cnt=1, sequence repeats on relock.
- soft_restart pulse in RUN on the same cycle lock_s falls -> WAIT_LOCK, lock_loss_cnt unchanged. soft_restart in WAIT_LOCK -> no effect.
- Force 300 lock losses with LOSS_CNT_W=8 -> lock_loss_cnt saturates at 255.
- rst asserted mid-STAGGER -> next cycle all outputs at reset values, lock_loss_cnt=0. Throughout all tests, assert rst_pix=0 implies rst_serdes=0.

Source files
------------

// File: rtl/tmds_clk_reset_seq.sv
// Staged reset sequencer for the HDMI TMDS path: waits for a stable PLL lock,
// releases the serializer reset, then the pixel-domain reset a few cycles later.
module tmds_clk_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  soft_restart,
    output logic                  rst_serdes,
    output logic                  rst_pix,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);
    localparam int STB_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [STG_W-1:0] STAGGER_LAST = STG_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        STAGGER   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 cur_state, nxt_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [STB_W-1:0]       stable_cnt;
    logic [STG_W-1:0]       stagger_cnt;
    logic                   loss;
    logic                   serdes_d, pix_d, ready_d;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            cur_state     <= WAIT_LOCK;
            stable_cnt    <= '0;
            stagger_cnt   <= '0;
            rst_serdes    <= 1'b1;
            rst_pix       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            cur_state   <= nxt_state;
            // Counters restart from zero on every entry into their state.
            stable_cnt  <= (cur_state == STABILIZE && nxt_state == STABILIZE)
                           ? stable_cnt + 1'b1 : '0;
            stagger_cnt <= (cur_state == STAGGER && nxt_state == STAGGER)
                           ? stagger_cnt + 1'b1 : '0;
            rst_serdes  <= serdes_d;
            rst_pix     <= pix_d;
            ready       <= ready_d;
            if (loss && lock_loss_cnt != '1)
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end

    // soft_restart outranks a lock drop, so a simultaneous drop is not a loss.
    always_comb begin
        nxt_state = cur_state;
        loss      = 1'b0;
        case (cur_state)
            WAIT_LOCK: if (lock_s) nxt_state = STABILIZE;
            STABILIZE: begin
                if (soft_restart || !lock_s)     nxt_state = WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST) nxt_state = STAGGER;
            end
            STAGGER: begin
                if (soft_restart) nxt_state = WAIT_LOCK;
                else if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                    loss      = 1'b1;
                end else if (stagger_cnt == STAGGER_LAST) nxt_state = RUN;
            end
            RUN: begin
                if (soft_restart) nxt_state = WAIT_LOCK;
                else if (!lock_s) begin
                    nxt_state = WAIT_LOCK;
                    loss      = 1'b1;
                end
            end
            default: nxt_state = WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        serdes_d = (nxt_state == WAIT_LOCK) || (nxt_state == STABILIZE);
        pix_d    = (nxt_state != RUN);
        ready_d  = (nxt_state == RUN);
    end
endmodule

// File: tb/tb_tmds_clk_reset_seq.sv
// Scoreboard bench: a phase/age reference model predicts every cycle's outputs;
// shortened stabilize/stagger lengths keep the 300-loss saturation run short.
module tb_tmds_clk_reset_seq;
    localparam int SYNC    = 2;
    localparam int STABLE  = 64;
    localparam int STAGGER = 8;
    localparam int W       = 8;
    localparam int EW      = 5 + W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_lock = 1'b0;
    logic         soft_restart = 1'b0;
    logic         rst_serdes, rst_pix, ready;
    logic [1:0]   state;
    logic [W-1:0] lock_loss_cnt;

    tmds_clk_reset_seq #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
        .STAGGER_CYCLES(STAGGER), .LOSS_CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .soft_restart(soft_restart),
        .rst_serdes(rst_serdes), .rst_pix(rst_pix), .ready(ready),
        .state(state), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: the sequence is "active" with an age counted from the
    // first STABILIZE cycle; the phase follows from the age alone.
    bit   m_active = 1'b0;
    int   m_age    = 0;
    int   m_loss   = 0;
    logic m_hist[SYNC];

    function automatic int phase();
        if (!m_active)                return 0;
        if (m_age < STABLE)           return 1;
        if (m_age < STABLE + STAGGER) return 2;
        return 3;
    endfunction

    task automatic model_step(input logic r, input logic lk, input logic sr);
        int   ph;
        logic ls;
        logic [W-1:0] cnt;
        if (r) begin
            m_active = 1'b0; m_age = 0; m_loss = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        end else begin
            ls = m_hist[SYNC-1];
            ph = phase();
            if (ph == 0) begin
                if (ls) begin m_active = 1'b1; m_age = 0; end
            end else if (sr) m_active = 1'b0;
            else if (!ls) begin
                if (ph >= 2) m_loss++;
                m_active = 1'b0;
            end else if (m_age < STABLE + STAGGER) m_age++;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = lk;
        end
        ph  = phase();
        cnt = (m_loss > (1 << W) - 1) ? W'((1 << W) - 1) : W'(m_loss);
        exp_q.push_back({2'(ph), ph < 2, ph < 3, ph == 3, cnt});
    endtask

    task automatic step(input logic r, input logic lk, input logic sr);
        @(negedge clk);
        rst = r; pll_lock = lk; soft_restart = sr;
        model_step(r, lk, sr);
        @(posedge clk);
    endtask

    task automatic steps(input int n, input logic lk);
        for (int i = 0; i < n; i++) step(1'b0, lk, 1'b0);
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        logic [EW-1:0] exp_v, got_v;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                got_v = {state, rst_serdes, rst_pix, ready, lock_loss_cnt};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got st=%0d sd=%b px=%b rdy=%b cnt=%0d exp st=%0d sd=%b px=%b rdy=%b cnt=%0d",
                             cycle, got_v[EW-1-:2], got_v[W+2], got_v[W+1], got_v[W], got_v[W-1:0],
                             exp_v[EW-1-:2], exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
                end
                checks++;
                if (!rst_pix && rst_serdes) begin
                    errors++;
                    $display("FAIL order cyc=%0d rst_pix=%b rst_serdes=%b exp rst_serdes=0", cycle, rst_pix, rst_serdes);
                end
            end
        end
    end

    initial begin
        int iter;
        // Reset with lock already high, then a clean bring-up to RUN.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        steps(SYNC + 1 + STABLE + STAGGER + 4, 1'b1);

        // Restart, then a one-cycle lock glitch mid-stabilize (not a loss).
        step(1'b0, 1'b1, 1'b1);
        steps(32, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        steps(SYNC + 1 + STABLE + STAGGER + 4, 1'b1);

        // Lock drop in RUN: one loss, then relock.
        steps(6, 1'b0);
        steps(SYNC + 1 + STABLE + STAGGER + 4, 1'b1);

        // soft_restart on the cycle lock_s falls: no loss counted.
        steps(SYNC, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(3, 1'b0);
        step(1'b0, 1'b0, 1'b1);           // ignored in WAIT_LOCK, lock low
        steps(SYNC, 1'b1);
        step(1'b0, 1'b1, 1'b1);           // ignored in WAIT_LOCK, lock_s high
        steps(STABLE + STAGGER + 4, 1'b1);

        // Reset in the middle of STAGGER.
        steps(4, 1'b0);
        steps(SYNC + 1 + STABLE + 3, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        steps(SYNC + 1 + STABLE + STAGGER + 2, 1'b1);

        // Randomized lock on/off runs until the loss counter saturates.
        iter = 0;
        while (m_loss < 300 && iter < 900) begin
            int hi;
            hi = $urandom_range(60, 90);
            for (int i = 0; i < hi; i++)
                step(1'b0, 1'b1, ($urandom_range(0, 199) == 0));
            steps($urandom_range(1, 4), 1'b0);
            iter++;
        end
        steps(SYNC + 2, 1'b0);

        #2;
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate got=%0d exp=255", lock_loss_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
